// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path.
//   tx_state_t   : transmitter FSM states
//   UART_DATA_W  : data bits per frame
//   LINE_IDLE    : serial line level between frames
//   calc_parity  : parity bit for a data byte (odd = 1 selects odd parity)
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  function automatic logic calc_parity(input logic [UART_DATA_W-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Byte input handshake of the UART transmitter.
//   in_data  : byte to transmit
//   in_valid : in_data is valid this cycle
//   in_ready : transmitter can accept a byte
// master = byte source, slave = transmitter.
interface uart_tx_fifo_if;
  import uart_pkg::*;

  logic [UART_DATA_W-1:0] in_data;
  logic                   in_valid;
  logic                   in_ready;

  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset.
//   clk, reset_n : clock, reset (clears pointers and count)
//   push, wdata  : write request/data, ignored when full
//   pop          : read request, ignored when empty
//   rdata        : head entry (valid when !empty)
//   full, empty  : status derived from the registered count
//   count        : number of entries held (0..DEPTH)
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: bytes enter a FIFO over a valid/ready handshake
// and are sent as start bit, 8 data bits LSB-first, optional parity and
// 1 or 2 stop bits, each bit lasting CLK_DIV clocks.
//   txclk      : clock
//   reset_n    : synchronous active-low reset, aborts any frame in progress
//   in_bus     : byte handshake (in_data/in_valid/in_ready)
//   tx_enable  : permits new frames; sampled in IDLE and at end of STOP
//   tx_out     : serial line, idle high
//   tx_busy    : a frame is on the line
//   fifo_count : bytes currently queued
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                          txclk,
  input  logic                          reset_n,
  uart_tx_fifo_if.slave                 in_bus,
  input  logic                          tx_enable,
  output logic                          tx_out,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(UART_DATA_W);

  tx_state_t              state;
  logic [BAUD_W-1:0]      baud_cnt;
  logic [BIT_W-1:0]       bit_cnt;
  logic [UART_DATA_W-1:0] shreg;
  logic                   par_bit;

  logic                   fifo_full;
  logic                   fifo_empty;
  logic [UART_DATA_W-1:0] head;
  logic                   bit_end;
  logic                   stop_done;
  logic                   pop;

  assign in_bus.in_ready = !fifo_full;

  assign bit_end   = (baud_cnt == BAUD_W'(CLK_DIV - 1));
  assign stop_done = (state == ST_STOP) && bit_end && (bit_cnt == BIT_W'(STOP_BITS - 1));
  // Popping at the end of the last stop bit lets the next start bit follow
  // immediately with no idle cycle.
  assign pop       = tx_enable && !fifo_empty && ((state == ST_IDLE) || stop_done);

  uart_sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (txclk),
    .reset_n (reset_n),
    .push    (in_bus.in_valid),
    .wdata   (in_bus.in_data),
    .pop     (pop),
    .rdata   (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge txclk) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      tx_out   <= LINE_IDLE;
      tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_bit  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          tx_out   <= LINE_IDLE;
          tx_busy  <= 1'b0;
          if (pop) begin
            shreg   <= head;
            par_bit <= calc_parity(head, PARITY_ODD != 0);
            state   <= ST_START;
            tx_out  <= 1'b0;
            tx_busy <= 1'b1;
          end
        end

        ST_START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_DATA;
            tx_out   <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_W'(UART_DATA_W - 1)) begin
              bit_cnt <= '0;
              if (PARITY_EN != 0) begin
                state  <= ST_PARITY;
                tx_out <= par_bit;
              end else begin
                state  <= ST_STOP;
                tx_out <= LINE_IDLE;
              end
            end else begin
              // shreg[0] is the bit on the line; shreg[1] goes out next.
              bit_cnt <= bit_cnt + BIT_W'(1);
              shreg   <= shreg >> 1;
              tx_out  <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            state    <= ST_STOP;
            tx_out   <= LINE_IDLE;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        ST_STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (stop_done) begin
              bit_cnt <= '0;
              if (pop) begin
                shreg   <= head;
                par_bit <= calc_parity(head, PARITY_ODD != 0);
                state   <= ST_START;
                tx_out  <= 1'b0;
              end else begin
                state   <= ST_IDLE;
                tx_out  <= LINE_IDLE;
                tx_busy <= 1'b0;
              end
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end

        default: begin
          state    <= ST_IDLE;
          tx_out   <= LINE_IDLE;
          tx_busy  <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo. Four instances, all CLK_DIV=4, FIFO_DEPTH=4:
//   0: no parity, 1 stop    1: even parity, 1 stop
//   2: odd parity, 1 stop   3: no parity, 2 stops
// Accepted bytes go into a scoreboard queue; a line decoder per instance
// pops and compares every frame it receives.
module tb_uart_tx_fifo;

  localparam int DIV = 4;

  typedef struct packed {
    logic [1:0] inst;
    logic [7:0] data;
    logic       par;
  } exp_t;

  logic       clk;
  logic [3:0] rst_v;
  logic [3:0] en_v;
  logic [3:0] vld_v;
  logic [7:0] din_v [4];

  logic       txo0, txo1, txo2, txo3;
  logic       busy0, busy1, busy2, busy3;
  logic [2:0] cnt0, cnt1, cnt2, cnt3;

  uart_tx_fifo_if bus0 ();
  uart_tx_fifo_if bus1 ();
  uart_tx_fifo_if bus2 ();
  uart_tx_fifo_if bus3 ();

  assign bus0.in_data = din_v[0];
  assign bus1.in_data = din_v[1];
  assign bus2.in_data = din_v[2];
  assign bus3.in_data = din_v[3];
  assign bus0.in_valid = vld_v[0];
  assign bus1.in_valid = vld_v[1];
  assign bus2.in_valid = vld_v[2];
  assign bus3.in_valid = vld_v[3];

  uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
    .txclk(clk), .reset_n(rst_v[0]), .in_bus(bus0), .tx_enable(en_v[0]),
    .tx_out(txo0), .tx_busy(busy0), .fifo_count(cnt0));
  uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
    .txclk(clk), .reset_n(rst_v[1]), .in_bus(bus1), .tx_enable(en_v[1]),
    .tx_out(txo1), .tx_busy(busy1), .fifo_count(cnt1));
  uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
    .txclk(clk), .reset_n(rst_v[2]), .in_bus(bus2), .tx_enable(en_v[2]),
    .tx_out(txo2), .tx_busy(busy2), .fifo_count(cnt2));
  uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_dut3 (
    .txclk(clk), .reset_n(rst_v[3]), .in_bus(bus3), .tx_enable(en_v[3]),
    .tx_out(txo3), .tx_busy(busy3), .fifo_count(cnt3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   abort_gen [4] = '{0, 0, 0, 0};
  logic line_log [256];
  // 0x55 frame: start, data LSB-first, stop
  int   exp_lv [10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 1};
  logic [7:0] t3_bytes [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

  function automatic logic txo(input int i);
    case (i)
      0: return txo0;
      1: return txo1;
      2: return txo2;
      default: return txo3;
    endcase
  endfunction

  function automatic logic busy(input int i);
    case (i)
      0: return busy0;
      1: return busy1;
      2: return busy2;
      default: return busy3;
    endcase
  endfunction

  function automatic logic rdy(input int i);
    case (i)
      0: return bus0.in_ready;
      1: return bus1.in_ready;
      2: return bus2.in_ready;
      default: return bus3.in_ready;
    endcase
  endfunction

  function automatic int cnt(input int i);
    case (i)
      0: return int'(cnt0);
      1: return int'(cnt1);
      2: return int'(cnt2);
      default: return int'(cnt3);
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Push one byte; optionally record it in the scoreboard when accepted.
  task automatic push(input int idx, input logic [7:0] d, input logic par, input bit expect_it);
    int n;
    @(negedge clk);
    din_v[idx] = d;
    vld_v[idx] = 1'b1;
    n = 0;
    while (!rdy(idx) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(idx)) begin
      chk("push_timeout", 0, 1);
      vld_v[idx] = 1'b0;
    end else begin
      @(posedge clk);
      if (expect_it) sb_q.push_back('{inst: 2'(idx), data: d, par: par});
      #1;
      vld_v[idx] = 1'b0;
    end
  endtask

  // Called #1 after an edge; logs tx_out each cycle while tx_busy stays high.
  task automatic trace_busy(input int idx, output int len);
    len = 0;
    while (busy(idx) && len < 256) begin
      line_log[len] = txo(idx);
      len++;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_sb_empty(input string name);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    chk(name, sb_q.size(), 0);
  endtask

  // Line decoder: samples each bit mid-period on the falling clock edge.
  task automatic mon(input int idx, input bit par_en, input int nstop);
    logic [7:0] d;
    logic       p;
    logic       framing;
    int         gen;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (txo(idx) == 1'b0) begin
        gen = abort_gen[idx];
        p = 1'b0;
        repeat (DIV / 2) @(negedge clk);
        framing = (txo(idx) == 1'b0);
        for (int b = 0; b < 8; b++) begin
          repeat (DIV) @(negedge clk);
          d[b] = txo(idx);
        end
        if (par_en) begin
          repeat (DIV) @(negedge clk);
          p = txo(idx);
        end
        for (int s = 0; s < nstop; s++) begin
          repeat (DIV) @(negedge clk);
          if (txo(idx) != 1'b1) framing = 1'b0;
        end
        if (gen == abort_gen[idx]) begin
          n_cmp++;
          if (sb_q.size() == 0) begin
            n_err++;
            $display("FAIL frame: inst %0d sent %02h with nothing expected", idx, d);
          end else begin
            e = sb_q.pop_front();
            if (int'(e.inst) != idx || e.data != d || (par_en && e.par != p) || !framing) begin
              n_err++;
              $display("FAIL frame: got inst %0d data %02h par %b framing %b, expected inst %0d data %02h par %b framing 1",
                       idx, d, p, framing, e.inst, e.data, e.par);
            end
          end
        end
      end
    end
  endtask

  initial begin
    int len;
    int bad;

    rst_v = 4'b0000;
    en_v  = 4'b0000;
    vld_v = 4'b0000;
    for (int i = 0; i < 4; i++) din_v[i] = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_out", int'(txo0), 1);
    chk("reset_tx_busy", int'(busy0), 0);
    chk("reset_fifo_count", cnt(0), 0);
    chk("reset_in_ready", int'(rdy(0)), 1);
    @(negedge clk);
    rst_v = 4'b1111;

    fork
      mon(0, 1'b0, 1);
      mon(1, 1'b1, 1);
      mon(2, 1'b1, 1);
      mon(3, 1'b0, 2);
    join_none

    // 1: single 0x55 frame, latency and waveform
    en_v[0] = 1'b1;
    push(0, 8'h55, 1'b0, 1'b1);
    chk("t1_line_at_push_edge", int'(txo0), 1);
    chk("t1_count_after_push", cnt(0), 1);
    @(posedge clk);
    #1;
    chk("t1_start_latency", int'(txo0), 0);
    trace_busy(0, len);
    chk("t1_busy_len", len, 40);
    for (int b = 0; b < 10; b++) begin
      bad = 0;
      for (int c = 0; c < DIV; c++) if (int'(line_log[b * DIV + c]) != exp_lv[b]) bad++;
      chk("t1_bit_level_errors", bad, 0);
    end
    chk("t1_idle_after", int'(txo0), 1);
    wait_sb_empty("t1_sb_drain");

    // 2: parity
    en_v[1] = 1'b1;
    en_v[2] = 1'b1;
    push(1, 8'h03, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    trace_busy(1, len);
    chk("t2_even03_len", len, 44);
    chk("t2_even03_par", int'(line_log[37]), 0);
    push(1, 8'h07, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    trace_busy(1, len);
    chk("t2_even07_par", int'(line_log[37]), 1);
    push(2, 8'h03, 1'b1, 1'b1);
    @(posedge clk);
    #1;
    trace_busy(2, len);
    chk("t2_odd03_len", len, 44);
    chk("t2_odd03_par", int'(line_log[37]), 1);
    wait_sb_empty("t2_sb_drain");

    // 3: fill with tx disabled, valid held across five bytes
    en_v[0] = 1'b0;
    @(negedge clk);
    vld_v[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din_v[0] = t3_bytes[i];
      chk("t3_ready_before_fill", int'(rdy(0)), 1);
      @(posedge clk);
      sb_q.push_back('{inst: 2'd0, data: t3_bytes[i], par: 1'b0});
      #1;
    end
    din_v[0] = t3_bytes[4];
    repeat (3) @(posedge clk);
    #1;
    chk("t3_count_full", cnt(0), 4);
    chk("t3_ready_full", int'(rdy(0)), 0);
    chk("t3_still_idle", int'(busy0), 0);
    en_v[0] = 1'b1;
    len = 0;
    while (!rdy(0) && len < 200) begin
      @(negedge clk);
      len++;
    end
    chk("t3_ready_returns", int'(rdy(0)), 1);
    @(posedge clk);
    sb_q.push_back('{inst: 2'd0, data: t3_bytes[4], par: 1'b0});
    #1;
    vld_v[0] = 1'b0;
    wait_sb_empty("t3_sb_drain");
    while (busy0 && len < 400) begin
      @(posedge clk);
      len++;
    end
    #1;

    // 4: back-to-back with two stop bits
    en_v[3] = 1'b1;
    push(3, 8'hA5, 1'b0, 1'b1);
    push(3, 8'h3C, 1'b0, 1'b1);
    trace_busy(3, len);
    chk("t4_busy_len", len, 88);
    chk("t4_stop_first", int'(line_log[36]), 1);
    chk("t4_stop_last", int'(line_log[43]), 1);
    chk("t4_second_start", int'(line_log[44]), 0);
    wait_sb_empty("t4_sb_drain");

    // 5: drop tx_enable during bit3 with a second byte queued
    push(0, 8'hC3, 1'b0, 1'b1);
    push(0, 8'h96, 1'b0, 1'b1);
    repeat (17) @(posedge clk);
    #1;
    en_v[0] = 1'b0;
    trace_busy(0, len);
    chk("t5_remaining_len", len, 23);
    repeat (5) @(posedge clk);
    #1;
    chk("t5_line_high", int'(txo0), 1);
    chk("t5_not_busy", int'(busy0), 0);
    chk("t5_count", cnt(0), 1);
    en_v[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_restart_line", int'(txo0), 0);
    chk("t5_restart_busy", int'(busy0), 1);
    wait_sb_empty("t5_sb_drain");
    len = 0;
    while (busy0 && len < 200) begin
      @(posedge clk);
      len++;
    end
    #1;

    // 6: reset mid-DATA with two bytes queued
    push(0, 8'hE7, 1'b0, 1'b0);
    push(0, 8'h18, 1'b0, 1'b0);
    push(0, 8'h81, 1'b0, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    chk("t6_busy_before", int'(busy0), 1);
    chk("t6_count_before", cnt(0), 2);
    @(negedge clk);
    rst_v[0] = 1'b0;
    abort_gen[0]++;
    @(posedge clk);
    #1;
    chk("t6_tx_out", int'(txo0), 1);
    chk("t6_tx_busy", int'(busy0), 0);
    chk("t6_fifo_count", cnt(0), 0);
    chk("t6_in_ready", int'(rdy(0)), 1);
    @(negedge clk);
    rst_v[0] = 1'b1;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk);
      #1;
      if (busy0 || !txo0) bad++;
    end
    chk("t6_no_frames_after", bad, 0);
    chk("t6_sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
